// File: rtl/serdes_deserializer.sv
// serdes_deserializer: packs p_n_samples val/rdy words into one wide val/rdy message
module serdes_deserializer #(
  parameter int p_bit_width = 32,
  parameter int p_n_samples = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [p_bit_width-1:0]             recv_msg,
  input  logic                               recv_val,
  output logic                               recv_rdy,
  output logic [p_bit_width*p_n_samples-1:0] send_msg,
  output logic                               send_val,
  input  logic                               send_rdy
);
  localparam int CW = p_n_samples > 1 ? $clog2(p_n_samples) : 1;
  typedef enum logic {COLLECT, FULL} state_t;
  state_t                                        state_q;
  logic [CW-1:0]                                 count_q;
  logic [p_n_samples-1:0][p_bit_width-1:0]       slot_q;
  assign recv_rdy = state_q == COLLECT;
  assign send_val = state_q == FULL;
  assign send_msg = slot_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= COLLECT;
      count_q <= '0;
      slot_q  <= '0;
    end else if (state_q == COLLECT) begin
      if (recv_val) begin
        slot_q[count_q] <= recv_msg;
        count_q         <= count_q == CW'(p_n_samples - 1) ? '0 : count_q + 1'b1;
        state_q         <= count_q == CW'(p_n_samples - 1) ? FULL : COLLECT;
      end
    end else if (send_rdy) begin
      state_q <= COLLECT;
    end
  end
endmodule
